// File: rtl/dds_sweep_scheduler_if.sv
// Sweep configuration, control and frequency-word output bundle for dds_sweep_scheduler.
interface dds_sweep_scheduler_if #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DWELL_W = 24
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [31:0]        cfg_start_word;
  logic [31:0]        cfg_step_word;
  logic [CNT_W-1:0]   cfg_n_steps;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_loop;
  logic               cfg_tri;
  logic               start;
  logic               abort;
  logic               direct_valid;
  logic [31:0]        direct_word;
  logic [31:0]        fre_word;
  logic               fre_strobe;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   step_idx;

  // Command side: drives configuration and control, observes the word output.
  modport master (
    output cfg_valid, cfg_start_word, cfg_step_word, cfg_n_steps, cfg_dwell,
           cfg_loop, cfg_tri, start, abort, direct_valid, direct_word,
    input  cfg_ready, fre_word, fre_strobe, busy, done, step_idx
  );

  // Scheduler side.
  modport slave (
    input  cfg_valid, cfg_start_word, cfg_step_word, cfg_n_steps, cfg_dwell,
           cfg_loop, cfg_tri, start, abort, direct_valid, direct_word,
    output cfg_ready, fre_word, fre_strobe, busy, done, step_idx
  );
endinterface

// File: rtl/dds_sweep_scheduler.sv
// Linear frequency-sweep sequencer with direct-word override for the DDS frequency input.
module dds_sweep_scheduler #(
  parameter logic [31:0] RESET_WORD = 32'd21474836,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DWELL_W    = 24
) (
  input logic                  clk,
  input logic                  rst,
  dds_sweep_scheduler_if.slave bus
);

  typedef enum logic [0:0] {S_IDLE, S_DWELL} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]        r_start_word;
  logic [31:0]        r_step_word;
  logic [CNT_W-1:0]   r_n_steps;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_loop;
  logic               r_tri;

  logic [31:0]        r_fre_word;
  logic               r_fre_strobe;
  logic               r_done;
  logic [CNT_W-1:0]   r_step_idx;
  logic               r_dir_up;
  logic [DWELL_W-1:0] r_cnt;

  logic [31:0]        w_fre_word_nxt;
  logic               w_fre_strobe_nxt;
  logic               w_done_nxt;
  logic [CNT_W-1:0]   w_step_idx_nxt;
  logic               w_dir_up_nxt;
  logic [DWELL_W-1:0] w_cnt_nxt;

  logic               w_cfg_take;
  logic [31:0]        w_eff_start;
  logic [CNT_W-1:0]   w_eff_n;
  logic [DWELL_W-1:0] w_eff_dwell;
  logic [DWELL_W-1:0] w_start_load;
  logic [DWELL_W-1:0] w_reload;
  logic               w_step_due;
  logic [CNT_W-1:0]   w_idx_inc;
  logic               w_pass_end;
  logic [31:0]        w_stepped_word;

  // A start coinciding with cfg_valid sees the incoming configuration directly.
  assign w_cfg_take     = (r_state == S_IDLE) && bus.cfg_valid;
  assign w_eff_start    = w_cfg_take ? bus.cfg_start_word : r_start_word;
  assign w_eff_n        = w_cfg_take ? bus.cfg_n_steps    : r_n_steps;
  assign w_eff_dwell    = w_cfg_take ? bus.cfg_dwell      : r_dwell;
  assign w_start_load   = (w_eff_dwell == '0) ? DWELL_W'(1) : w_eff_dwell;
  assign w_reload       = (r_dwell == '0) ? DWELL_W'(1) : r_dwell;
  assign w_step_due     = (r_cnt <= DWELL_W'(1));
  assign w_idx_inc      = r_step_idx + CNT_W'(1);
  assign w_pass_end     = (w_idx_inc == r_n_steps);
  assign w_stepped_word = r_dir_up ? (r_fre_word + r_step_word) : (r_fre_word - r_step_word);

  // Configuration registers, writable only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_word <= '0;
      r_step_word  <= '0;
      r_n_steps    <= '0;
      r_dwell      <= '0;
      r_loop       <= 1'b0;
      r_tri        <= 1'b0;
    end else if (w_cfg_take) begin
      r_start_word <= bus.cfg_start_word;
      r_step_word  <= bus.cfg_step_word;
      r_n_steps    <= bus.cfg_n_steps;
      r_dwell      <= bus.cfg_dwell;
      r_loop       <= bus.cfg_loop;
      r_tri        <= bus.cfg_tri;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decision; a direct update always returns to idle.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.direct_valid) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (bus.start && (w_eff_n != '0)) w_state_nxt = S_DWELL;
        S_DWELL: begin
          if (bus.abort)                                  w_state_nxt = S_IDLE;
          else if (w_step_due && w_pass_end && !r_loop)   w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Word, strobe, index, direction and dwell-counter updates.
  always_comb begin
    w_fre_word_nxt   = r_fre_word;
    w_fre_strobe_nxt = 1'b0;
    w_done_nxt       = 1'b0;
    w_step_idx_nxt   = r_step_idx;
    w_dir_up_nxt     = r_dir_up;
    w_cnt_nxt        = r_cnt;
    if (bus.direct_valid) begin
      w_fre_word_nxt   = bus.direct_word;
      w_fre_strobe_nxt = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_fre_word_nxt   = w_eff_start;
            w_fre_strobe_nxt = 1'b1;
            w_step_idx_nxt   = '0;
            if (w_eff_n == '0) begin
              w_done_nxt = 1'b1;
            end else begin
              w_dir_up_nxt = 1'b1;
              w_cnt_nxt    = w_start_load;
            end
          end
        end
        S_DWELL: begin
          if (!bus.abort) begin
            if (w_step_due) begin
              w_cnt_nxt        = w_reload;
              w_fre_strobe_nxt = 1'b1;
              if (w_pass_end) begin
                if (!r_loop) begin
                  w_fre_word_nxt = w_stepped_word;
                  w_step_idx_nxt = w_idx_inc;
                  w_done_nxt     = 1'b1;
                end else if (!r_tri) begin
                  w_fre_word_nxt = r_start_word;
                  w_step_idx_nxt = '0;
                end else begin
                  w_fre_word_nxt = w_stepped_word;
                  w_dir_up_nxt   = ~r_dir_up;
                  w_step_idx_nxt = '0;
                end
              end else begin
                w_fre_word_nxt = w_stepped_word;
                w_step_idx_nxt = w_idx_inc;
              end
            end else begin
              w_cnt_nxt = r_cnt - DWELL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fre_word   <= RESET_WORD;
      r_fre_strobe <= 1'b0;
      r_done       <= 1'b0;
      r_step_idx   <= '0;
      r_dir_up     <= 1'b1;
      r_cnt        <= '0;
    end else begin
      r_fre_word   <= w_fre_word_nxt;
      r_fre_strobe <= w_fre_strobe_nxt;
      r_done       <= w_done_nxt;
      r_step_idx   <= w_step_idx_nxt;
      r_dir_up     <= w_dir_up_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  assign bus.cfg_ready  = (r_state == S_IDLE);
  assign bus.busy       = (r_state == S_DWELL);
  assign bus.fre_word   = r_fre_word;
  assign bus.fre_strobe = r_fre_strobe;
  assign bus.done       = r_done;
  assign bus.step_idx   = r_step_idx;

endmodule
